// File: rtl/ram_pkg.sv
// Shared definitions for the RAM BIST controller.
//   DW_DEF / AW_DEF : default RAM data / address widths
//   state_t         : controller state encoding
//   pattern()       : fill / expected word for an address, seed + address
package ram_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;
  // pattern() works at a fixed width; callers cast back down to DW, which
  // gives the mod 2^DW wrap. Supports DW up to 32.
  localparam int PAT_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_VZERO = 3'd2,
    S_FILL  = 3'd3,
    S_VPAT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                               input logic [PAT_W-1:0] add);
    return seed + add;
  endfunction
endpackage

// File: rtl/ram_bist_ctrl_if.sv
// RAM write/read port between the BIST controller (master) and the RAM (slave).
//   mem_reset, mem_write_en, mem_add, mem_write_data : master -> RAM
//   mem_read_data                                    : RAM -> master
interface ram_bist_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          mem_reset;
  logic          mem_write_en;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  modport master (
    output mem_reset, mem_write_en, mem_add, mem_write_data,
    input  mem_read_data
  );
  modport slave (
    input  mem_reset, mem_write_en, mem_add, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/ram_rd_align.sv
// Delay line that lines up the issued {valid, address, expected} with the
// RAM read data that returns LAT cycles later.
//   clk, reset : clock, async active-high reset (clears the line)
//   d          : payload aligned with the driven address
//   q          : payload aligned with the returning read data
module ram_rd_align #(
  parameter int W   = 1,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  generate
    if (LAT == 0) begin : g_wire
      // Combinational RAM: compare in the same cycle the address is driven.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign q = d;
    end else begin : g_pipe
      logic [LAT-1:0][W-1:0] sr;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sr <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[LAT-1];
    end
  endgenerate
endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM built-in self-test controller. On start: optional clear + verify-zero,
// then fill every word with seed + address, then read back and compare.
//   clk, reset        : clock, async active-high reset
//   start             : run request (IDLE only); clear_first, seed sampled with it
//   mem               : RAM port (master side), all outputs registered
//   busy, done        : run in progress / one-cycle end pulse
//   pass              : no mismatches in the finished run, held until next start
//   err_count         : saturating mismatch count over both verify passes
//   first_err_add     : address of the first mismatch
module ram_bist_ctrl
  import ram_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          clear_first,
  input  logic [DW-1:0] seed,
  ram_bist_ctrl_if.master mem,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_count,
  output logic [AW-1:0] first_err_add
);
  localparam int N  = 1 << AW;
  // Wide enough to count N + RD_LAT verify cycles.
  localparam int CW = AW + 2;

  state_t        state;
  logic [DW-1:0] seed_q;
  logic [CW-1:0] cnt;
  logic          iss_vld;
  logic [DW-1:0] iss_exp;

  logic          d_vld;
  logic [AW-1:0] d_add;
  logic [DW-1:0] d_exp;
  logic          miss;
  logic [AW+1:0] err_next;
  logic [AW-1:0] nxt_add;
  logic [DW-1:0] pat_nxt;
  logic          last_cmp;

  // Payload travels alongside the registered address so it meets its data.
  ram_rd_align #(.W(1 + AW + DW), .LAT(RD_LAT)) u_align (
    .clk   (clk),
    .reset (reset),
    .d     ({iss_vld, mem.mem_add, iss_exp}),
    .q     ({d_vld, d_add, d_exp})
  );

  assign miss     = d_vld && (mem.mem_read_data != d_exp);
  assign err_next = (miss && (err_count != '1)) ? err_count + 1'b1 : err_count;
  assign nxt_add  = mem.mem_add + 1'b1;
  assign pat_nxt  = DW'(pattern(PAT_W'(seed_q), PAT_W'(nxt_add)));
  assign last_cmp = (cnt == CW'(N - 1 + RD_LAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      seed_q             <= '0;
      cnt                <= '0;
      iss_vld            <= 1'b0;
      iss_exp            <= '0;
      mem.mem_reset      <= 1'b0;
      mem.mem_write_en   <= 1'b0;
      mem.mem_add        <= '0;
      mem.mem_write_data <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      err_count          <= '0;
      first_err_add      <= '0;
    end else begin
      done <= 1'b0;
      if (miss) begin
        err_count <= err_next;
        if (err_count == '0) first_err_add <= d_add;
      end

      case (state)
        S_IDLE: if (start) begin
          seed_q        <= seed;
          err_count     <= '0;
          first_err_add <= '0;
          pass          <= 1'b0;
          busy          <= 1'b1;
          cnt           <= '0;
          mem.mem_add   <= '0;
          if (clear_first) begin
            state         <= S_CLEAR;
            mem.mem_reset <= 1'b1;
          end else begin
            // Address 0 write is presented in the first FILL cycle.
            state              <= S_FILL;
            mem.mem_write_en   <= 1'b1;
            mem.mem_write_data <= seed;
          end
        end

        S_CLEAR: begin
          mem.mem_reset <= 1'b0;
          state         <= S_VZERO;
          iss_vld       <= 1'b1;
          iss_exp       <= '0;
          mem.mem_add   <= '0;
          cnt           <= '0;
        end

        S_VZERO, S_VPAT: begin
          cnt <= cnt + 1'b1;
          if (cnt < CW'(N - 1)) begin
            mem.mem_add <= nxt_add;
            iss_exp     <= (state == S_VZERO) ? '0 : pat_nxt;
          end else begin
            // Addresses exhausted; keep draining the delay line.
            iss_vld     <= 1'b0;
            iss_exp     <= '0;
            mem.mem_add <= '0;
          end
          if (last_cmp) begin
            cnt <= '0;
            if (state == S_VZERO) begin
              state              <= S_FILL;
              mem.mem_write_en   <= 1'b1;
              mem.mem_write_data <= seed_q;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // err_next includes the compare happening on this edge.
              pass  <= (err_next == '0);
            end
          end
        end

        S_FILL: begin
          if (cnt == CW'(N - 1)) begin
            state              <= S_VPAT;
            cnt                <= '0;
            mem.mem_write_en   <= 1'b0;
            mem.mem_write_data <= '0;
            mem.mem_add        <= '0;
            iss_vld            <= 1'b1;
            iss_exp            <= seed_q;
          end else begin
            cnt                <= cnt + 1'b1;
            mem.mem_add        <= nxt_add;
            mem.mem_write_data <= pat_nxt;
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RD_LAT=1 RAM.
module tb_ram_bist_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          clear_first = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [AW+1:0] err_count;
  logic [AW-1:0] first_err_add;

  int vecs = 0;
  int errs = 0;

  ram_bist_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram_bist_ctrl #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear_first   (clear_first),
    .seed          (seed),
    .mem           (bus),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_add (first_err_add)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read (1-cycle latency).
  // fault_en makes bit 0 of address 5 read back as 1.
  logic [DW-1:0] ram [N];
  logic [DW-1:0] rd_q;
  logic          preload = 1'b0;
  logic          fault_en = 1'b0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) ram[i] <= 8'hAA;
    end else if (bus.mem_reset) begin
      for (int i = 0; i < N; i++) ram[i] <= '0;
    end else if (bus.mem_write_en) begin
      ram[bus.mem_add] <= bus.mem_write_data;
    end
    rd_q <= (fault_en && bus.mem_add == 3'd5) ? (ram[bus.mem_add] | 8'h01) : ram[bus.mem_add];
  end
  assign bus.mem_read_data = rd_q;

  // Observations from the last run.
  int                      busy_cyc, done_cyc, rst_cyc, wr_cnt;
  logic                    busy_at_done, pass_early;
  logic [N-1:0][DW-1:0]    wr_dat;
  logic [N-1:0][DW-1:0]    exp_dat;

  // Cycle c=1 is the first cycle after the edge that accepts start.
  task automatic run_bist(input logic [DW-1:0] s, input logic clr,
                          input int extra_a, input int extra_b);
    int c;
    busy_cyc = 0; done_cyc = 0; rst_cyc = 0; wr_cnt = 0;
    busy_at_done = 1'b1; pass_early = 1'b1; wr_dat = '0;
    @(negedge clk);
    seed = s; clear_first = clr; start = 1'b1;
    @(negedge clk);
    // Change the inputs after acceptance; the run must use the latched values.
    start = 1'b0; seed = 8'h5A; clear_first = ~clr;
    c = 1;
    while (done_cyc == 0 && c < 100) begin
      if (c == 1) pass_early = pass;
      if (busy) busy_cyc++;
      if (bus.mem_reset) rst_cyc++;
      if (bus.mem_write_en) begin
        wr_cnt++;
        wr_dat[bus.mem_add] = bus.mem_write_data;
      end
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
      end
      start = (c == extra_a || c == extra_b);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({busy, done, pass, err_count, first_err_add} !== '0) begin
      errs++;
      $display("FAIL reset_status: got %b required 0", {busy, done, pass, err_count, first_err_add});
    end
    vecs++;
    if ({bus.mem_reset, bus.mem_write_en, bus.mem_add, bus.mem_write_data} !== '0) begin
      errs++;
      $display("FAIL reset_mem: got %b required 0",
               {bus.mem_reset, bus.mem_write_en, bus.mem_add, bus.mem_write_data});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_bist(8'h10, 1'b0, 0, 0);
    vecs++;
    if (done_cyc !== 18) begin errs++; $display("FAIL basic_done_cycle: got %0d required 18", done_cyc); end
    vecs++;
    if (busy_cyc !== 17) begin errs++; $display("FAIL basic_busy_cycles: got %0d required 17", busy_cyc); end
    vecs++;
    if (busy_at_done !== 1'b0) begin errs++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_done); end
    vecs++;
    if (rst_cyc !== 0 || wr_cnt !== 8) begin
      errs++; $display("FAIL basic_bus_counts: got reset=%0d writes=%0d required 0/8", rst_cyc, wr_cnt);
    end
    exp_dat = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    vecs++;
    if (wr_dat !== exp_dat) begin errs++; $display("FAIL basic_write_data: got %h required %h", wr_dat, exp_dat); end
    vecs++;
    if (pass !== 1'b1 || err_count !== 5'd0) begin
      errs++; $display("FAIL basic_result: got pass=%b err=%0d required 1/0", pass, err_count);
    end
    // Now in the cycle after done: pulse over, pass still held.
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      errs++; $display("FAIL basic_after_done: got done=%b busy=%b pass=%b required 0/0/1", done, busy, pass);
    end
  endtask

  task automatic test_wrap();
    run_bist(8'hFC, 1'b0, 0, 0);
    exp_dat = {8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
    vecs++;
    if (wr_dat !== exp_dat) begin errs++; $display("FAIL wrap_write_data: got %h required %h", wr_dat, exp_dat); end
    vecs++;
    if (pass !== 1'b1 || err_count !== 5'd0 || done_cyc !== 18) begin
      errs++; $display("FAIL wrap_result: got pass=%b err=%0d done@%0d required 1/0/18", pass, err_count, done_cyc);
    end
  endtask

  task automatic test_clear();
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    run_bist(8'h21, 1'b1, 0, 0);
    vecs++;
    if (rst_cyc !== 1) begin errs++; $display("FAIL clear_reset_cycles: got %0d required 1", rst_cyc); end
    vecs++;
    if (busy_cyc !== 27 || done_cyc !== 28) begin
      errs++; $display("FAIL clear_run_length: got busy=%0d done@%0d required 27/28", busy_cyc, done_cyc);
    end
    vecs++;
    if (pass !== 1'b1 || err_count !== 5'd0) begin
      errs++; $display("FAIL clear_result: got pass=%b err=%0d required 1/0", pass, err_count);
    end
  endtask

  // Address 5 holds seed+5; seed 01 makes that word 06, whose bit 0 is 0,
  // so the stuck bit is visible in the pattern pass as well as after clear.
  task automatic test_fault();
    fault_en = 1'b1;
    run_bist(8'h01, 1'b0, 0, 0);
    vecs++;
    if (err_count !== 5'd1 || first_err_add !== 3'd5 || pass !== 1'b0) begin
      errs++; $display("FAIL fault_fill_only: got err=%0d add=%0d pass=%b required 1/5/0", err_count, first_err_add, pass);
    end
    run_bist(8'h01, 1'b1, 0, 0);
    vecs++;
    if (err_count !== 5'd2 || first_err_add !== 3'd5 || pass !== 1'b0 || done_cyc !== 28) begin
      errs++; $display("FAIL fault_with_clear: got err=%0d add=%0d pass=%b done@%0d required 2/5/0/28",
                       err_count, first_err_add, pass, done_cyc);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic found;
    int   done_hits;
    found = 1'b0; done_hits = 0;
    @(negedge clk);
    seed = 8'h20; clear_first = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.mem_write_en && bus.mem_add == 3'd3) found = 1'b1;
      else @(negedge clk);
    end
    vecs++;
    if (found !== 1'b1) begin errs++; $display("FAIL midreset_reach_add3: got %b required 1", found); end
    reset = 1'b1;
    #1;
    vecs++;
    if ({busy, done, pass, err_count, first_err_add, bus.mem_reset, bus.mem_write_en,
         bus.mem_add, bus.mem_write_data} !== '0) begin
      errs++; $display("FAIL midreset_async_clear: got busy=%b we=%b add=%0d wd=%h required all 0",
                       busy, bus.mem_write_en, bus.mem_add, bus.mem_write_data);
    end
    repeat (3) begin @(negedge clk); if (done) done_hits++; end
    reset = 1'b0;
    repeat (25) begin @(negedge clk); if (done || busy) done_hits++; end
    vecs++;
    if (done_hits !== 0) begin errs++; $display("FAIL midreset_no_done: got %0d active cycles required 0", done_hits); end
    run_bist(8'h30, 1'b0, 0, 0);
    exp_dat = {8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h30};
    vecs++;
    if (wr_dat !== exp_dat || done_cyc !== 18 || pass !== 1'b1 || err_count !== 5'd0) begin
      errs++; $display("FAIL midreset_rerun: got data=%h done@%0d pass=%b err=%0d required %h/18/1/0",
                       wr_dat, done_cyc, pass, err_count, exp_dat);
    end
  endtask

  task automatic test_back_to_back();
    run_bist(8'h40, 1'b0, 5, 12);
    vecs++;
    if (done_cyc !== 18 || busy_cyc !== 17) begin
      errs++; $display("FAIL restart_length: got done@%0d busy=%0d required 18/17", done_cyc, busy_cyc);
    end
    exp_dat = {8'h47, 8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h40};
    vecs++;
    if (wr_dat !== exp_dat || pass !== 1'b1 || err_count !== 5'd0) begin
      errs++; $display("FAIL restart_result: got data=%h pass=%b err=%0d required %h/1/0", wr_dat, pass, err_count, exp_dat);
    end
    // Previous run passed; accepting start must have cleared pass.
    vecs++;
    if (pass_early !== 1'b0) begin errs++; $display("FAIL restart_pass_cleared: got %b required 0", pass_early); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_clear();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
